// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline encodings, fetch FSM states and target select helper
package pipe_pkg;

  localparam logic [1:0]  PCS_SEQ  = 2'b00;
  localparam logic [1:0]  PCS_BR   = 2'b01;
  localparam logic [1:0]  PCS_JR   = 2'b10;
  localparam logic [1:0]  PCS_J    = 2'b11;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] pcs_target(input logic [1:0]  pcs,
                                             input logic [31:0] bpc,
                                             input logic [31:0] rpc,
                                             input logic [31:0] jpc);
    logic [31:0] tgt;
    tgt = bpc;
    case (pcs)
      PCS_JR:  tgt = rpc;
      PCS_J:   tgt = jpc;
      default: tgt = bpc;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/pipe_ifid_reg.sv
// rtl/pipe_ifid_reg.sv - enable-controlled pc4/instruction pipeline register, resets to a bubble
module pipe_ifid_reg
  import pipe_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_WORD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] next_pc4,
  input  logic [31:0] next_inst,
  output logic [31:0] pc4,
  output logic [31:0] inst
);

  always_ff @(posedge clock) begin
    if (reset) begin
      pc4  <= 32'h0;
      inst <= NOP_INST;
    end else if (en) begin
      pc4  <= next_pc4;
      inst <= next_inst;
    end
  end

endmodule

// File: rtl/pipe_fetch_stage.sv
// rtl/pipe_fetch_stage.sv - IF stage: PC, next-PC select, imem handshake and IF/ID register
module pipe_fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_WORD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic        wpcir,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] dinst
);

  fetch_state_e state;
  logic         redir_pend;
  logic [31:0]  redir_pc;
  logic [31:0]  hold_inst;
  logic [31:0]  hold_pc4;

  logic         br_valid;
  logic [31:0]  tgt;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic [31:0]  ifid_pc4;
  logic [31:0]  ifid_inst;

  // pcsource is only trusted when ID is not stalled; its operands may be stale otherwise
  assign br_valid  = wpcir && (pcsource != PCS_SEQ);
  assign tgt       = pcs_target(pcsource, bpc, rpc, jpc);
  assign pc_plus4  = pc + 32'd4;
  assign next_pc   = br_valid ? tgt : (redir_pend ? redir_pc : pc_plus4);

  assign imem_req  = (state == RUN) && !reset;
  assign imem_addr = pc;

  always_comb begin
    ifid_pc4  = dpc4;
    ifid_inst = NOP_INST;
    if (state == HOLD) begin
      ifid_pc4  = hold_pc4;
      ifid_inst = hold_inst;
    end else if (imem_ack) begin
      ifid_pc4  = pc_plus4;
      ifid_inst = imem_rdata;
    end
  end

  // IF/ID loads whenever ID can accept: a real instruction or a bubble
  pipe_ifid_reg #(
    .NOP_INST (NOP_INST)
  ) u_ifid (
    .clock     (clock),
    .reset     (reset),
    .en        (wpcir),
    .next_pc4  (ifid_pc4),
    .next_inst (ifid_inst),
    .pc4       (dpc4),
    .inst      (dinst)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      pc         <= RESET_PC;
      state      <= RUN;
      redir_pend <= 1'b0;
      redir_pc   <= 32'h0;
      hold_inst  <= 32'h0;
      hold_pc4   <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (imem_ack) begin
            if (wpcir) begin
              pc         <= next_pc;
              redir_pend <= 1'b0;
            end else begin
              hold_inst <= imem_rdata;
              hold_pc4  <= pc_plus4;
              state     <= HOLD;
            end
          end else if (br_valid) begin
            // delay slot still outstanding: remember where to go once it lands
            redir_pc   <= tgt;
            redir_pend <= 1'b1;
          end
        end
        HOLD: begin
          if (wpcir) begin
            pc         <= next_pc;
            redir_pend <= 1'b0;
            state      <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
